// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC and issues credit-limited word fetches.
// Returned words are tagged with their PC, buffered in a small FIFO and handed to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   req_pc_r;
  logic          inflight_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];

  logic          head_valid_s;
  logic          bypass_s;
  logic          credit_s;
  logic          push_s;
  logic          pop_s;

  // Credit, handshake and head/bypass selection.
  // An empty FIFO with a response arriving presents the memory word directly,
  // giving single-cycle request-to-valid latency.
  always_comb begin
    head_valid_s = (count_r != {CW{1'b0}});
    bypass_s     = !head_valid_s && inflight_r;
    credit_s     = (({1'b0, count_r} + {{CW{1'b0}}, inflight_r}) < DEPTH_W);
    imem_req     = rst && credit_s && !redirect_valid;
    imem_addr    = pc_r;
    out_valid    = (head_valid_s || bypass_s) && !redirect_valid;
    pop_s        = head_valid_s && out_ready && !redirect_valid;
    push_s       = inflight_r && !redirect_valid && !(bypass_s && out_ready);
    if (head_valid_s) begin
      out_instr = instr_mem_r[rd_ptr_r];
      out_pc    = pc_mem_r[rd_ptr_r];
    end else if (bypass_s) begin
      out_instr = imem_rdata;
      out_pc    = req_pc_r;
    end else begin
      out_instr = 32'h0000_0000;
      out_pc    = 32'h0000_0000;
    end
  end

  // PC, in-flight tracking and FIFO pointers/occupancy; a redirect flushes the FIFO
  // and, since no request is issued in that cycle, the in-flight flag drops with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= RESET_PC;
      req_pc_r   <= 32'h0000_0000;
      inflight_r <= 1'b0;
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
    end else begin
      inflight_r <= imem_req;
      if (imem_req) begin
        pc_r     <= pc_r + 32'd4;
        req_pc_r <= pc_r;
      end else if (redirect_valid) begin
        pc_r     <= {redirect_pc[31:2], 2'b00};
      end
      if (redirect_valid) begin
        count_r  <= {CW{1'b0}};
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

  // FIFO storage: data only, validity is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= req_pc_r;
    end
  end

endmodule
